// File: rtl/trig_pkg.sv
// Shared types and default constants for the trigger-clock source stage
// and its button debouncer.
package trig_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } db_state_t;

  localparam int DB_CNT_W       = 20;
  localparam int DB_CYCLES_DEF  = 1_000_000;
  localparam int DIV_BIT_DEF    = 24;
  localparam int PULSE_W_DEF    = 16;

endpackage

// File: rtl/step_clk_gen_if.sv
// Signal bundle between the trigger-clock source and the flip-flop boards.
// No valid/ready handshake here: btn_raw/sel_clk are asynchronous levels, all outputs are registered levels/strobes.
interface step_clk_gen_if;
  import trig_pkg::*;

  logic        btn_raw;
  logic        sel_clk;
  logic [31:0] div;
  logic        step_pulse;
  logic [15:0] step_count;
  logic        mode;
  logic        CK;
  db_state_t   db_state;

  // master: the clock source itself; slave: whatever drives the controls and consumes CK.
  modport master (
    input  btn_raw, sel_clk,
    output div, step_pulse, step_count, mode, CK, db_state
  );

  modport slave (
    output btn_raw, sel_clk,
    input  div, step_pulse, step_count, mode, CK, db_state
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-FF synchronizer, press/release qualification FSM,
// and a one-cycle strobe on each accepted press.
module btn_debounce
  import trig_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      btn_raw,
  output logic      step_pulse,
  output db_state_t state
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic [1:0]          sync_q;
  logic                btn_s;
  db_state_t           state_q, state_next;
  logic [DB_CNT_W-1:0] db_cnt, db_cnt_next;
  logic                pulse_next;

  assign btn_s = sync_q[1];
  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b00;
      state_q    <= IDLE;
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_raw};
      state_q    <= state_next;
      db_cnt     <= db_cnt_next;
      step_pulse <= pulse_next;
    end
  end

  always_comb begin
    state_next = state_q;
    pulse_next = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) state_next = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_next = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_next = HELD;
          pulse_next = 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) state_next = REL_CHK;
      end
      REL_CHK: begin
        if (btn_s) begin
          state_next = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // The counter only matters in the two checking states; it restarts on every state entry.
    if (state_next != state_q || state_q == IDLE || state_q == HELD) begin
      db_cnt_next = '0;
    end else begin
      db_cnt_next = db_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/step_clk_gen.sv
// Trigger-clock source: free-running divider, debounced single-step pulse
// stretched to PULSE_W cycles, and a glitch-free mux driving the registered CK.
module step_clk_gen
  import trig_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DIV_BIT   = DIV_BIT_DEF,
  parameter int PULSE_W   = PULSE_W_DEF
) (
  input  logic           clk,
  input  logic           RSTN,
  step_clk_gen_if.master bus
);

  localparam int            SW         = $clog2(PULSE_W + 1);
  localparam logic [SW-1:0] PULSE_LOAD = SW'(PULSE_W);

  logic [1:0]    sel_sync;
  logic          sel_s;
  logic [31:0]   div_r;
  logic [SW-1:0] str_cnt;
  logic          stretch;
  logic          load;
  logic [15:0]   step_cnt_r;
  logic          mode_r, mode_next;
  logic          ck_r, ck_next;
  logic          div_tap, target;
  logic          step_pulse;
  db_state_t     db_state;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (RSTN),
    .btn_raw    (bus.btn_raw),
    .step_pulse (step_pulse),
    .state      (db_state)
  );

  assign sel_s   = sel_sync[1];
  assign div_tap = div_r[DIV_BIT];
  assign stretch = (str_cnt != '0);
  // A press landing inside an active stretch is dropped entirely.
  assign load    = step_pulse && !stretch;

  // Switch only when both the current output and the incoming source are low,
  // so CK never emits a shortened high phase.
  always_comb begin
    target    = sel_s ? stretch : div_tap;
    mode_next = mode_r;
    if (!ck_r && !target) mode_next = sel_s;
    ck_next   = mode_next ? stretch : div_tap;
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      sel_sync   <= 2'b00;
      div_r      <= '0;
      str_cnt    <= '0;
      step_cnt_r <= '0;
      mode_r     <= 1'b0;
      ck_r       <= 1'b0;
    end else begin
      sel_sync   <= {sel_sync[0], bus.sel_clk};
      div_r      <= div_r + 32'd1;
      if (load) begin
        str_cnt <= PULSE_LOAD;
      end else if (stretch) begin
        str_cnt <= str_cnt - 1'b1;
      end
      step_cnt_r <= step_cnt_r + 16'(load);
      mode_r     <= mode_next;
      ck_r       <= ck_next;
    end
  end

  assign bus.div        = div_r;
  assign bus.step_pulse = step_pulse;
  assign bus.step_count = step_cnt_r;
  assign bus.mode       = mode_r;
  assign bus.CK         = ck_r;
  assign bus.db_state   = db_state;

endmodule

// File: tb/tb_step_clk_gen.sv
// Directed bench for step_clk_gen: instance A (DB_CYCLES=4, PULSE_W=3, DIV_BIT=2)
// and instance B (DB_CYCLES=1, PULSE_W=8) for a press landing inside a stretch.
module tb_step_clk_gen;
  import trig_pkg::*;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;
  int   hi_len;
  int   runt_cnt;
  bit   mon_en;

  step_clk_gen_if bus_a ();
  step_clk_gen_if bus_b ();

  step_clk_gen #(.DB_CYCLES(4), .DIV_BIT(2), .PULSE_W(3)) dut_a (
    .clk (clk), .RSTN (rstn), .bus (bus_a)
  );

  step_clk_gen #(.DB_CYCLES(1), .DIV_BIT(2), .PULSE_W(8)) dut_b (
    .clk (clk), .RSTN (rstn), .bus (bus_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CK high-phase length monitor on instance A
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_a.CK) begin
        hi_len++;
      end else begin
        if (hi_len > 0 && hi_len < 3) runt_cnt++;
        hi_len = 0;
      end
    end else begin
      hi_len = 0;
    end
  end

  task automatic test_reset();
    rstn = 1'b0;
    bus_a.btn_raw = 1'b0; bus_a.sel_clk = 1'b0;
    bus_b.btn_raw = 1'b0; bus_b.sel_clk = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus_a.div !== 32'd0) begin n_err++; $display("FAIL rst_div got %0h want 0", bus_a.div); end
    n_cmp++; if (bus_a.CK !== 1'b0) begin n_err++; $display("FAIL rst_ck got %0b want 0", bus_a.CK); end
    n_cmp++; if (bus_a.step_count !== 16'd0) begin n_err++; $display("FAIL rst_cnt got %0d want 0", bus_a.step_count); end
    n_cmp++; if (bus_a.mode !== 1'b0) begin n_err++; $display("FAIL rst_mode got %0b want 0", bus_a.mode); end
    n_cmp++; if (bus_a.step_pulse !== 1'b0) begin n_err++; $display("FAIL rst_pulse got %0b want 0", bus_a.step_pulse); end
    n_cmp++; if (bus_a.db_state !== IDLE) begin n_err++; $display("FAIL rst_state got %0d want %0d", bus_a.db_state, IDLE); end
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++; if (bus_a.div !== 32'(k)) begin n_err++; $display("FAIL rst_count k=%0d got %0d want %0d", k, bus_a.div, k); end
    end
  endtask

  // Entered with div==2 at the current negedge, divider mode.
  task automatic test_divider();
    int d;
    logic exp_ck;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      d = 2 + k;
      exp_ck = ((d - 1) >> 2) & 1;
      n_cmp++; if (bus_a.div !== 32'(d)) begin n_err++; $display("FAIL div_val k=%0d got %0d want %0d", k, bus_a.div, d); end
      n_cmp++; if (bus_a.CK !== exp_ck) begin n_err++; $display("FAIL div_ck k=%0d got %0b want %0b", k, bus_a.CK, exp_ck); end
      n_cmp++; if (bus_a.mode !== 1'b0) begin n_err++; $display("FAIL div_mode k=%0d got %0b want 0", k, bus_a.mode); end
    end
  endtask

  task automatic test_clean_press();
    logic        exp_pulse, exp_ck;
    logic [15:0] exp_cnt;
    bus_a.sel_clk = 1'b1;
    for (int i = 0; i < 30 && bus_a.mode !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (bus_a.mode !== 1'b1) begin n_err++; $display("FAIL press_mode_timeout got %0b want 1", bus_a.mode); end
    n_cmp++; if (bus_a.CK !== 1'b0) begin n_err++; $display("FAIL press_ck_idle got %0b want 0", bus_a.CK); end
    bus_a.btn_raw = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      exp_pulse = (k == 7);
      exp_ck    = (k >= 9 && k <= 11);
      exp_cnt   = (k >= 8) ? 16'd1 : 16'd0;
      n_cmp++; if (bus_a.step_pulse !== exp_pulse) begin n_err++; $display("FAIL press_pulse k=%0d got %0b want %0b", k, bus_a.step_pulse, exp_pulse); end
      n_cmp++; if (bus_a.CK !== exp_ck) begin n_err++; $display("FAIL press_ck k=%0d got %0b want %0b", k, bus_a.CK, exp_ck); end
      n_cmp++; if (bus_a.step_count !== exp_cnt) begin n_err++; $display("FAIL press_cnt k=%0d got %0d want %0d", k, bus_a.step_count, exp_cnt); end
    end
    bus_a.btn_raw = 1'b0;
    for (int i = 0; i < 20 && bus_a.db_state !== IDLE; i++) @(negedge clk);
    n_cmp++; if (bus_a.db_state !== IDLE) begin n_err++; $display("FAIL press_release_timeout got %0d want %0d", bus_a.db_state, IDLE); end
  endtask

  task automatic test_bounce();
    logic [4:0]  pat;
    logic        exp_pulse, exp_ck;
    logic [15:0] exp_cnt;
    pat = 5'b10101;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      if (k <= 4) bus_a.btn_raw = pat[k];
      exp_pulse = (k == 11);
      exp_ck    = (k >= 13 && k <= 15);
      exp_cnt   = (k >= 12) ? 16'd2 : 16'd1;
      n_cmp++; if (bus_a.step_pulse !== exp_pulse) begin n_err++; $display("FAIL bounce_pulse k=%0d got %0b want %0b", k, bus_a.step_pulse, exp_pulse); end
      n_cmp++; if (bus_a.CK !== exp_ck) begin n_err++; $display("FAIL bounce_ck k=%0d got %0b want %0b", k, bus_a.CK, exp_ck); end
      n_cmp++; if (bus_a.step_count !== exp_cnt) begin n_err++; $display("FAIL bounce_cnt k=%0d got %0d want %0d", k, bus_a.step_count, exp_cnt); end
    end
    bus_a.btn_raw = 1'b0;
    for (int i = 0; i < 20 && bus_a.db_state !== IDLE; i++) @(negedge clk);
    n_cmp++; if (bus_a.db_state !== IDLE) begin n_err++; $display("FAIL bounce_release_timeout got %0d want %0d", bus_a.db_state, IDLE); end
  endtask

  task automatic test_switch_while_high();
    logic exp_mode, exp_ck;
    bus_a.sel_clk = 1'b0;
    for (int i = 0; i < 30 && bus_a.mode !== 1'b0; i++) @(negedge clk);
    n_cmp++; if (bus_a.mode !== 1'b0) begin n_err++; $display("FAIL sw_to_div_timeout got %0b want 0", bus_a.mode); end
    for (int i = 0; i < 16 && bus_a.div[2:0] !== 3'd4; i++) @(negedge clk);
    n_cmp++; if (bus_a.div[2:0] !== 3'd4) begin n_err++; $display("FAIL sw_phase_timeout got %0d want 4", bus_a.div[2:0]); end
    bus_a.sel_clk = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      exp_mode = (k >= 6);
      exp_ck   = (k >= 1 && k <= 4);
      n_cmp++; if (bus_a.mode !== exp_mode) begin n_err++; $display("FAIL sw_mode k=%0d got %0b want %0b", k, bus_a.mode, exp_mode); end
      n_cmp++; if (bus_a.CK !== exp_ck) begin n_err++; $display("FAIL sw_ck k=%0d got %0b want %0b", k, bus_a.CK, exp_ck); end
    end
    n_cmp++; if (runt_cnt !== 0) begin n_err++; $display("FAIL sw_runt got %0d want 0", runt_cnt); end
  endtask

  task automatic test_reset_mid();
    mon_en = 1'b0;
    bus_a.btn_raw = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (bus_a.CK !== 1'b1) begin n_err++; $display("FAIL mid_ck_pre got %0b want 1", bus_a.CK); end
    #1 rstn = 1'b0;
    #1;
    n_cmp++; if (bus_a.CK !== 1'b0) begin n_err++; $display("FAIL mid_ck got %0b want 0", bus_a.CK); end
    n_cmp++; if (bus_a.div !== 32'd0) begin n_err++; $display("FAIL mid_div got %0h want 0", bus_a.div); end
    n_cmp++; if (bus_a.step_count !== 16'd0) begin n_err++; $display("FAIL mid_cnt got %0d want 0", bus_a.step_count); end
    n_cmp++; if (bus_a.mode !== 1'b0) begin n_err++; $display("FAIL mid_mode got %0b want 0", bus_a.mode); end
    n_cmp++; if (bus_a.db_state !== IDLE) begin n_err++; $display("FAIL mid_state got %0d want %0d", bus_a.db_state, IDLE); end
    bus_a.btn_raw = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++; if (bus_a.div !== 32'(k)) begin n_err++; $display("FAIL mid_count k=%0d got %0d want %0d", k, bus_a.div, k); end
    end
    mon_en = 1'b1;
  endtask

  task automatic test_press_during_stretch();
    logic        exp_pulse, exp_ck;
    logic [15:0] exp_cnt;
    for (int i = 0; i < 30 && bus_b.mode !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (bus_b.mode !== 1'b1) begin n_err++; $display("FAIL ds_mode_timeout got %0b want 1", bus_b.mode); end
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) @(negedge clk);
      bus_b.btn_raw = (k < 3 || k >= 5);
      exp_pulse = (k == 4 || k == 9);
      exp_ck    = (k >= 6 && k <= 13);
      exp_cnt   = (k >= 5) ? 16'd1 : 16'd0;
      n_cmp++; if (bus_b.step_pulse !== exp_pulse) begin n_err++; $display("FAIL ds_pulse k=%0d got %0b want %0b", k, bus_b.step_pulse, exp_pulse); end
      n_cmp++; if (bus_b.CK !== exp_ck) begin n_err++; $display("FAIL ds_ck k=%0d got %0b want %0b", k, bus_b.CK, exp_ck); end
      n_cmp++; if (bus_b.step_count !== exp_cnt) begin n_err++; $display("FAIL ds_cnt k=%0d got %0d want %0d", k, bus_b.step_count, exp_cnt); end
    end
    bus_b.btn_raw = 1'b0;
  endtask

  task automatic test_div_wrap();
    @(negedge clk);
    force dut_a.div_r = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut_a.div_r;
    @(negedge clk);
    n_cmp++; if (bus_a.div !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_max got %0h want ffffffff", bus_a.div); end
    @(negedge clk);
    n_cmp++; if (bus_a.div !== 32'd0) begin n_err++; $display("FAIL wrap_zero got %0h want 0", bus_a.div); end
    @(negedge clk);
    n_cmp++; if (bus_a.div !== 32'd1) begin n_err++; $display("FAIL wrap_one got %0h want 1", bus_a.div); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; hi_len = 0; runt_cnt = 0; mon_en = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_divider();
    test_clean_press();
    test_bounce();
    test_switch_while_high();
    test_reset_mid();
    test_press_during_stretch();
    test_div_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/step_clk_gen.md
# step_clk_gen

Upstream clock-source stage for the flip-flop demonstration boards. It debounces a push-button into a single-step pulse and runs a free-running 32-bit divider. It then drives the trigger clock `CK` from either a divider tap or the stretched step pulse, with glitch-free switching between the two. `CK` feeds the RS, D and master-slave flip-flop instances directly.

## Interface
- `DB_CYCLES`, 1_000_000: stable-level cycles required to accept a button edge (10 ms at 100 MHz).
- `DIV_BIT`, 24: divider bit used as the free-running clock source (0..31).
- `PULSE_W`, 16: width in clk cycles of each stretched step pulse (≥1).
- `clk` in 1: system clock, 100 MHz.
- `RSTN` in 1: reset, asynchronous, active-low.
- `btn_raw` in 1: raw, bouncing step button, asynchronous.
- `sel_clk` in 1: source select, asynchronous; 0 = divider, 1 = manual step.
- `div` out 32: free-running divider count.
- `step_pulse` out 1: one-cycle strobe per accepted button press.
- `step_count` out 16: number of accepted steps, wraps.
- `mode` out 1: currently active source; 1 = step.
- `CK` out 1: registered trigger clock.

## Operation
- **Reset values:** all outputs 0, FSM in IDLE, stretch counter 0, synchronizers 0.
- **Synchronizers:** `btn_raw` and `sel_clk` each pass through a 2-FF synchronizer, giving `btn_s` and `sel_s`.
- **Divider:** `div` increments every cycle and wraps from 0xFFFF_FFFF to 0.
- **Debounce FSM:** uses a 20-bit counter `db_cnt`, cleared on every state entry.
  - IDLE: `btn_s`=1 → PRESS_CHK.
  - PRESS_CHK: `btn_s`=0 → IDLE, no pulse. When `db_cnt`==DB_CYCLES-1 → HELD, with `step_pulse`=1 in the first HELD cycle.
  - HELD: `btn_s`=0 → REL_CHK.
  - REL_CHK: `btn_s`=1 → HELD, no pulse. When `db_cnt`==DB_CYCLES-1 → IDLE.
- **Stretcher:** `step_pulse` while the stretch counter is 0 loads it with PULSE_W. The counter decrements to 0, and `stretch` = (counter≠0). A `step_pulse` arriving while the counter is nonzero is ignored and not counted.
- **`step_count`:** increments once per accepted (stretcher-loading) step.
- **Glitch-free mux:** `mode` takes the value of `sel_s` only in a cycle where the current `CK` is 0 and the target source (`div[DIV_BIT]` or `stretch`) is also 0. Otherwise `mode` holds.
  - `CK` next value = `mode` ? `stretch` : `div[DIV_BIT]`, using the updated `mode`.
  - Consequence: `CK` never produces a runt high pulse on a switch.
- **Reset mid-operation:** every register returns asynchronously to its reset value. An in-progress stretch or debounce is abandoned, and `CK` drops to 0 immediately.

## Timing
- `btn_raw` rising at cycle 0 and held: `btn_s`=1 at cycle 2, PRESS_CHK at cycle 3, `step_pulse` at cycle 3+DB_CYCLES.
- `stretch` (and `CK` in step mode) rises 1 cycle after `step_pulse` and stays high exactly PULSE_W cycles. `CK` lags `stretch` by one register stage.
- In divider mode, `CK` = `div[DIV_BIT]` delayed 1 cycle, giving a period of 2^(DIV_BIT+1) cycles.
- A mode switch takes effect at the first qualifying cycle after `sel_s` changes. Worst case is one full period of the outgoing source plus sync latency.
- `step_count` updates in the same cycle `stretch` rises.

## Structure
- Package `trig_pkg`:
  - FSM state enum {IDLE, PRESS_CHK, HELD, REL_CHK}.
  - Default constants for DB_CYCLES, DIV_BIT and PULSE_W.
- Sub-module `btn_debounce`: synchronizer, FSM and `db_cnt`, with output `step_pulse`. It is reusable for the other board buttons.
- Divider, stretcher and mux live in the top body.

## Test plan
Bench parameters: DB_CYCLES=4, PULSE_W=3, DIV_BIT=2.
- **Reset:** assert `RSTN`=0 mid-stretch → `CK`, `div`, `step_count` and `mode` are 0 immediately. After release, `div` counts 0,1,2…
- **Clean press:** `btn_raw` high at cycle 0 and held → single `step_pulse` at cycle 7, `stretch` high cycles 8–10, `step_count`=1. Holding further produces no second pulse.
- **Bounce:** `btn_raw` toggled 1,0,1,0 on alternate cycles, then held → exactly one `step_pulse`, 4 stable cycles after the final rise is synchronized.
- **Divider mode:** `sel_clk`=0 → `CK` period 8 cycles, 4 high, 4 low. `div` wraps from 0xFFFF_FFFF to 0 when forced near the limit.
- **Switch while high:** switch `sel_clk` 0→1 while `div[2]`=1 → `mode` stays 0 until `CK`=0 and `stretch`=0. No `CK` high pulse shorter than 3 cycles appears.
- **Press during stretch:** press accepted, then a second press accepted inside the stretch window (DB_CYCLES overridden to 1) → ignored, `step_count` stays 1.
